// File: rtl/syncfifo_wr_arbiter.sv
// Round-robin arbiter sharing the syncfifo write port among N_REQ requesters, with credit-based occupancy tracking.
// Latency: accept edge -> registered write_en/data_in next cycle; gnt is combinational from registered state and req.
// Backpressure: gnt held at 0 while occupancy==DEPTH or fifo_full; optional macro SFIFO_ARB_BURST_EN enables owner bursts.
module syncfifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*WIDTH-1:0]       req_data,
  output logic [N_REQ-1:0]             gnt,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  input  logic                         fifo_read_en,
  output logic                         write_en,
  output logic [WIDTH-1:0]             data_in,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  logic [PW-1:0]    rr_ptr_q;
  logic [OW-1:0]    occupancy_q, occupancy_d;
  logic             write_en_q;
  logic [WIDTH-1:0] data_in_q;

  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  logic             win_found;
  logic [WIDTH-1:0] win_dat;
  logic             can_grant;
  logic             accept;
  logic             rd_eff;

`ifdef SFIFO_ARB_BURST_EN
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  logic [BW-1:0] burst_cnt_q;
  logic          prio_owner;
`endif

  // Pick the winner: the burst owner if it still has budget, else the first requester after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
`ifdef SFIFO_ARB_BURST_EN
    prio_owner = 1'b0;
    if (req[rr_ptr_q] && (burst_cnt_q < BURST_LAST)) begin
      win_found  = 1'b1;
      prio_owner = 1'b1;
    end
`endif
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant only with credit available and no full indication; nothing is granted while in reset.
  always_comb begin
    can_grant = reset && !fifo_full && (occupancy_q < DEPTH_C);
    gnt       = '0;
    if (can_grant && win_found) begin
      gnt[win_idx] = 1'b1;
    end
    accept = |(req & gnt);
    rd_eff = fifo_read_en && !fifo_empty;
  end

  // Mux out the winner's data word.
  always_comb begin
    win_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_dat = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Credit count: accept adds one, an effective read frees one, both together cancel.
  always_comb begin
    occupancy_d = occupancy_q;
    if (accept && !rd_eff) begin
      occupancy_d = occupancy_q + OCC_ONE;
    end else if (!accept && rd_eff && (occupancy_q != '0)) begin
      occupancy_d = occupancy_q - OCC_ONE;
    end
  end

  // Register the write beat, remember the last winner and update occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_en_q  <= 1'b0;
      data_in_q   <= '0;
      rr_ptr_q    <= PW'(N_REQ - 1);
      occupancy_q <= '0;
    end else begin
      write_en_q  <= accept;
      occupancy_q <= occupancy_d;
      if (accept) begin
        data_in_q <= win_dat;
        rr_ptr_q  <= win_idx;
      end
    end
  end

`ifdef SFIFO_ARB_BURST_EN
  // Count consecutive owner beats; any new owner, fresh search win or owner req drop restarts the burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt_q <= '0;
    end else if (accept) begin
      burst_cnt_q <= prio_owner ? (burst_cnt_q + BURST_ONE) : '0;
    end else if (!req[rr_ptr_q]) begin
      burst_cnt_q <= '0;
    end
  end
`endif

  assign write_en  = write_en_q;
  assign data_in   = data_in_q;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_syncfifo_wr_arbiter.sv
// Directed table-driven bench for syncfifo_wr_arbiter plus hand sequences for fill, async reset and rotation.
// Inputs are driven at the falling edge and outputs sampled 2 time units later, well before the rising edge.
// Expected values are hand-computed constants for N_REQ=4, WIDTH=8, DEPTH=16, MAX_BURST=4.
module tb_syncfifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_read_en;
  logic        write_en;
  logic [7:0]  data_in;
  logic [4:0]  occupancy;

  int n_vec;
  int n_err;

  syncfifo_wr_arbiter #(
    .N_REQ(4), .WIDTH(8), .DEPTH(16), .MAX_BURST(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_read_en (fifo_read_en),
    .write_en     (write_en),
    .data_in      (data_in),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    req          = '0;
    fifo_full    = 1'b0;
    fifo_empty   = 1'b1;
    fifo_read_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rd;
    logic       empty;
    logic       full;
    logic [3:0] gnt;
    logic       wen;
    logic [7:0] din;
    logic [4:0] occ;
  } vec_t;

  vec_t vt[16];
  int   acc;
  int   cyc;
  logic [3:0] exp_rot[8];

  initial begin
    n_vec    = 0;
    n_err    = 0;
    req_data = 32'hA3A2A1A0;
    do_reset();

`ifndef SFIFO_ARB_BURST_EN
    //        req    rd    empty full  gnt    wen   din    occ
    vt[0]  = '{4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 5'd0};
    vt[1]  = '{4'hF, 1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 8'h00, 5'd0};
    vt[2]  = '{4'hF, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA0, 5'd1};
    vt[3]  = '{4'hF, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 8'hA1, 5'd2};
    vt[4]  = '{4'hF, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 8'hA2, 5'd3};
    vt[5]  = '{4'hF, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 8'hA3, 5'd4};
    vt[6]  = '{4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 8'hA0, 5'd5};
    vt[7]  = '{4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'hA0, 5'd5};
    vt[8]  = '{4'h2, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 8'hA0, 5'd4};
    vt[9]  = '{4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 8'hA1, 5'd4};
    vt[10] = '{4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'hA1, 5'd4};
    vt[11] = '{4'hF, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'hA1, 5'd4};
    vt[12] = '{4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'hA1, 5'd3};
    vt[13] = '{4'h9, 1'b0, 1'b1, 1'b0, 4'h8, 1'b0, 8'hA1, 5'd3};
    vt[14] = '{4'h9, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 8'hA3, 5'd4};
    vt[15] = '{4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 8'hA0, 5'd5};

    for (int v = 0; v < 16; v++) begin
      req          = vt[v].req;
      fifo_read_en = vt[v].rd;
      fifo_empty   = vt[v].empty;
      fifo_full    = vt[v].full;
      #2;
      check($sformatf("v%0d gnt", v), 32'(gnt), 32'(vt[v].gnt));
      check($sformatf("v%0d write_en", v), 32'(write_en), 32'(vt[v].wen));
      check($sformatf("v%0d data_in", v), 32'(data_in), 32'(vt[v].din));
      check($sformatf("v%0d occupancy", v), 32'(occupancy), 32'(vt[v].occ));
      @(negedge clk);
    end
`endif

    // Fill to DEPTH with no reads: credit stops exactly at 16.
    do_reset();
    req = 4'hF;
    acc = 0;
    cyc = 0;
    #2;
    while (occupancy != 5'd16 && cyc < 40) begin
      if (|(req & gnt)) acc++;
      @(negedge clk);
      #2;
      cyc++;
    end
    check("fill occupancy", 32'(occupancy), 32'd16);
    check("fill accepts", 32'(acc), 32'd16);
    check("fill gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    fifo_read_en = 1'b1;
    fifo_empty   = 1'b0;
    #2;
    check("full read no bypass gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    fifo_read_en = 1'b0;
    #2;
    check("after read occupancy", 32'(occupancy), 32'd15);
`ifdef SFIFO_ARB_BURST_EN
    check("after read gnt", 32'(gnt), 32'h8);
`else
    check("after read gnt", 32'(gnt), 32'h1);
`endif
    if (|(req & gnt)) acc++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #2;
      if (|(req & gnt)) acc++;
    end
    check("refill accepts", 32'(acc), 32'd17);
    check("refill occupancy", 32'(occupancy), 32'd16);

    // Async reset with a registered write in flight.
    do_reset();
    req = 4'h1;
    #2;
    check("single gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'h0;
    #2;
    check("single write_en", 32'(write_en), 32'h1);
    check("single data_in", 32'(data_in), 32'hA0);
    check("single occupancy", 32'(occupancy), 32'd1);
    #1;
    reset = 1'b0;
    req   = 4'hF;
    #1;
    check("async rst write_en", 32'(write_en), 32'h0);
    check("async rst occupancy", 32'(occupancy), 32'd0);
    check("async rst gnt", 32'(gnt), 32'h0);
    @(negedge clk);

    // Two requesters held: strict alternation, or bursts of four with the burst option.
    do_reset();
`ifdef SFIFO_ARB_BURST_EN
    exp_rot = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
`else
    exp_rot = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2};
`endif
    req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      #2;
      check($sformatf("rotation gnt %0d", c), 32'(gnt), 32'(exp_rot[c]));
      @(negedge clk);
    end
    req = 4'h0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
